// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants, types and helpers for the multi-port register file
package regfile_pkg;

  // Upper bound on read ports supported by the register file.
  localparam int MAX_RD_PORTS = 4;

  // Index of a read port (0 .. MAX_RD_PORTS-1).
  typedef logic [1:0] rf_idx_t;

  // Address width for n registers; never narrower than one bit.
  function automatic int addr_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// rtl/regfile_rd_port.sv - one registered read port: range check, write bypass, busy select
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   en                read strobe for this port
//   addr              read address
//   reg_flat          all registers packed, register i at [i*WIDTH +: WIDTH]
//   busy_vec          per-register busy flags (state before this cycle's updates)
//   wr_ok             a qualified (in-range, permitted) write happens this cycle
//   wr_addr, wr_data  address and data of that write
//   data              registered read data (holds when en is low)
//   valid             high for one cycle after an accepted read
//   busy              registered busy status of the register read, aligned with data
module regfile_rd_port #(
  parameter int WIDTH    = 32,
  parameter int NUM_REGS = 16,
  parameter int AW       = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [AW-1:0]             addr,
  input  logic [NUM_REGS*WIDTH-1:0] reg_flat,
  input  logic [NUM_REGS-1:0]       busy_vec,
  input  logic                      wr_ok,
  input  logic [AW-1:0]             wr_addr,
  input  logic [WIDTH-1:0]          wr_data,
  output logic [WIDTH-1:0]          data,
  output logic                      valid,
  output logic                      busy
);

  localparam logic [AW:0] DEPTH = (AW+1)'(NUM_REGS);

  logic             in_range;
  logic             wr_hit;
  logic [WIDTH-1:0] sel_data;
  logic             sel_busy;

  assign in_range = ({1'b0, addr} < DEPTH);
  // wr_ok is already range-qualified, so a hit implies an in-range address.
  assign wr_hit   = wr_ok && (wr_addr == addr);

  // Write-first bypass: a same-cycle write supplies the data and clears the
  // busy view. A same-cycle reserve is intentionally not visible here.
  always_comb begin
    sel_data = '0;
    sel_busy = 1'b0;
    if (in_range) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (addr == AW'(i)) begin
          sel_data = reg_flat[i*WIDTH +: WIDTH];
          sel_busy = busy_vec[i];
        end
      end
      if (wr_hit) begin
        sel_data = wr_data;
        sel_busy = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data  <= '0;
      valid <= 1'b0;
      busy  <= 1'b0;
    end else begin
      valid <= en;
      if (en) begin
        data <= sel_data;
        busy <= sel_busy;
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - parametrised multi-read-port register file with busy scoreboard
//
// Optional feature macro: ZERO_REG_EN (register 0 hardwired to zero, never busy).
//
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   wr_en        write strobe; writes wr_data to wr_addr and clears its busy flag
//   wr_addr      write address
//   wr_data      write data
//   rsv_en       reserve strobe; marks rsv_addr busy (wins over a same-cycle write)
//   rsv_addr     register to reserve
//   rd_en        per-port read strobe
//   rd_addr      packed read addresses, port p at [p*AW +: AW]
//   rd_data      packed registered read data, port p at [p*WIDTH +: WIDTH]
//   rd_valid     per-port, high for one cycle after an accepted read
//   rd_busy      per-port busy status of the register read, aligned with rd_data
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               NUM_REGS  = 16,
  parameter int               NUM_RD    = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              AW        = addr_width(NUM_REGS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic                    rsv_en,
  input  logic [AW-1:0]           rsv_addr,
  input  logic [NUM_RD-1:0]       rd_en,
  input  logic [NUM_RD*AW-1:0]    rd_addr,
  output logic [NUM_RD*WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]       rd_valid,
  output logic [NUM_RD-1:0]       rd_busy
);

`ifdef ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  localparam logic [AW:0] DEPTH = (AW+1)'(NUM_REGS);

  logic [WIDTH-1:0]          regs [NUM_REGS];
  logic [NUM_REGS*WIDTH-1:0] reg_flat;
  logic [NUM_REGS-1:0]       busy;
  logic                      wr_ok;
  logic                      rsv_ok;

  // Out-of-range addresses are dropped; with a hardwired zero register,
  // address 0 accepts neither writes nor reserves (and so never bypasses).
  assign wr_ok  = wr_en && ({1'b0, wr_addr} < DEPTH)
                  && !(ZERO_REG && (wr_addr == '0));
  assign rsv_ok = rsv_en && ({1'b0, rsv_addr} < DEPTH)
                  && !(ZERO_REG && (rsv_addr == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= (ZERO_REG && (i == 0)) ? '0 : RESET_VAL;
      end
    end else if (wr_ok) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_addr == AW'(i)) begin
          regs[i] <= wr_data;
        end
      end
    end
  end

  // Reserve takes priority over a same-cycle write: a new producer has been
  // issued, so the register stays busy even though the data lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (rsv_ok && (rsv_addr == AW'(i))) begin
          busy[i] <= 1'b1;
        end else if (wr_ok && (wr_addr == AW'(i))) begin
          busy[i] <= 1'b0;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_pack
    assign reg_flat[g*WIDTH +: WIDTH] = regs[g];
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    regfile_rd_port #(
      .WIDTH    (WIDTH),
      .NUM_REGS (NUM_REGS),
      .AW       (AW)
    ) u_rd_port (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (rd_en[p]),
      .addr     (rd_addr[p*AW +: AW]),
      .reg_flat (reg_flat),
      .busy_vec (busy),
      .wr_ok    (wr_ok),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .data     (rd_data[p*WIDTH +: WIDTH]),
      .valid    (rd_valid[p]),
      .busy     (rd_busy[p])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed scoreboard bench for regfile_mp (12 regs, 3 read ports)
module tb_regfile_mp;
  import regfile_pkg::*;

  localparam int W  = 32;
  localparam int N  = 12;
  localparam int P  = 3;
  localparam int AW = 4;
  localparam logic [W-1:0] RV = 32'hA5A5_0F0F;

  logic            clk      = 1'b0;
  logic            rst_n    = 1'b0;
  logic            wr_en    = 1'b0;
  logic [AW-1:0]   wr_addr  = '0;
  logic [W-1:0]    wr_data  = '0;
  logic            rsv_en   = 1'b0;
  logic [AW-1:0]   rsv_addr = '0;
  logic [P-1:0]    rd_en    = '0;
  logic [P*AW-1:0] rd_addr  = '0;
  logic [P*W-1:0]  rd_data;
  logic [P-1:0]    rd_valid;
  logic [P-1:0]    rd_busy;

  typedef struct {
    int         port;
    logic [W-1:0] data;
    logic       valid;
    logic       busy;
    string      tag;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] last_data [P];
  logic         last_busy [P];
  logic         read_now  [P];
  int           errors = 0;
  int           checks = 0;

  regfile_mp #(
    .WIDTH     (W),
    .NUM_REGS  (N),
    .NUM_RD    (P),
    .RESET_VAL (RV)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_busy  (rd_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int p = 0; p < P; p++) begin
      last_data[p] = '0;
      last_busy[p] = 1'b0;
      read_now[p]  = 1'b0;
    end
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
  endtask

  task automatic rsv(input logic [AW-1:0] a);
    rsv_en   = 1'b1;
    rsv_addr = a;
  endtask

  // Drive a read on port p and queue what it must return after the edge.
  task automatic rd(input rf_idx_t p, input logic [AW-1:0] a,
                    input logic [W-1:0] d, input logic b, input string tag);
    rd_en[p]              = 1'b1;
    rd_addr[p*AW +: AW]   = a;
    read_now[p]           = 1'b1;
    last_data[p]          = d;
    last_busy[p]          = b;
    sb.push_back('{port: int'(p), data: d, valid: 1'b1, busy: b, tag: tag});
  endtask

  // One clock: idle ports are expected to hold with valid low, then all
  // queued expectations are popped and compared, and strobes are dropped.
  task automatic step();
    for (int p = 0; p < P; p++) begin
      if (!read_now[p]) begin
        sb.push_back('{port: p, data: last_data[p], valid: 1'b0,
                       busy: last_busy[p], tag: $sformatf("hold_p%0d", p)});
      end
    end
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check({e.tag, "_data"},  rd_data[e.port*W +: W],     e.data);
      check({e.tag, "_valid"}, W'(rd_valid[e.port]),       W'(e.valid));
      check({e.tag, "_busy"},  W'(rd_busy[e.port]),        W'(e.busy));
    end
    wr_en  = 1'b0;
    rsv_en = 1'b0;
    rd_en  = '0;
    for (int p = 0; p < P; p++) read_now[p] = 1'b0;
  endtask

  initial begin
    model_clear();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_data",  rd_data,         '0);
    check("reset_valid", W'(rd_valid),    '0);
    check("reset_busy",  W'(rd_busy),     '0);
    rst_n = 1'b1;

    // Reset value, then write-first bypass
    rd(0, 4'd5, RV, 1'b0, "rv_r5");
    step();
    wr(4'd3, 32'hDEAD_BEEF);
    rd(1, 4'd3, 32'hDEAD_BEEF, 1'b0, "bypass_r3");
    step();

    // Port independence and hold
    wr(4'd1, 32'h11);
    step();
    wr(4'd2, 32'h22);
    step();
    rd(0, 4'd1, 32'h11, 1'b0, "p0_r1");
    rd(1, 4'd2, 32'h22, 1'b0, "p1_r2");
    step();
    step();

    // Busy scoreboard
    rsv(4'd7);
    step();
    rd(2, 4'd7, RV, 1'b1, "busy_r7");
    step();
    wr(4'd7, 32'h5A);
    rd(2, 4'd7, 32'h5A, 1'b0, "wrclr_r7");
    step();
    rsv(4'd7);
    wr(4'd7, 32'h77);
    rd(0, 4'd7, 32'h77, 1'b0, "rsvwr_same_r7");
    step();
    rd(1, 4'd7, 32'h77, 1'b1, "rsvwr_after_r7");
    step();

    // Out-of-range addresses
    wr(4'd13, 32'h0000_0BAD);
    rsv(4'd13);
    step();
    rd(0, 4'd13, '0, 1'b0, "oor_r13");
    rd(1, 4'd5, RV, 1'b0, "noalias_r5");
    step();

    // All ports on the same address, stored and bypassed
    wr(4'd11, 32'hCAFE_0011);
    step();
    rd(0, 4'd11, 32'hCAFE_0011, 1'b0, "same_p0");
    rd(1, 4'd11, 32'hCAFE_0011, 1'b0, "same_p1");
    rd(2, 4'd11, 32'hCAFE_0011, 1'b0, "same_p2");
    step();
    wr(4'd11, 32'h0000_0BB0);
    rd(0, 4'd11, 32'h0000_0BB0, 1'b0, "samebyp_p0");
    rd(1, 4'd11, 32'h0000_0BB0, 1'b0, "samebyp_p1");
    rd(2, 4'd11, 32'h0000_0BB0, 1'b0, "samebyp_p2");
    step();

    // Asynchronous reset mid-operation
    rsv(4'd4);
    wr(4'd4, 32'h99);
    step();
    rd(0, 4'd4, 32'h99, 1'b1, "pre_rst_r4");
    step();
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_data",  rd_data,      '0);
    check("async_rst_valid", W'(rd_valid), '0);
    check("async_rst_busy",  W'(rd_busy),  '0);
    model_clear();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rd(0, 4'd4, RV, 1'b0, "post_rst_r4");
    rd(2, 4'd7, RV, 1'b0, "post_rst_r7");
    step();

    // Register 0
    wr(4'd0, 32'h0000_FFFF);
    rsv(4'd0);
`ifdef ZERO_REG_EN
    rd(1, 4'd0, '0, 1'b0, "zero_byp_r0");
    step();
    rd(2, 4'd0, '0, 1'b0, "zero_after_r0");
    step();
`else
    rd(1, 4'd0, 32'h0000_FFFF, 1'b0, "r0_byp");
    step();
    rd(2, 4'd0, 32'h0000_FFFF, 1'b1, "r0_after");
    step();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
